// File: rtl/bullet_scheduler_if.sv
// Bus bundle for the bullet scheduler: turret/keyboard inputs and slot state outputs.
// The master side (turret/game logic) drives the inputs; the scheduler is the slave.
interface bullet_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    // Inputs to the scheduler
    logic                        frame_tick;
    logic [7:0]                  keycode;
    logic [9:0]                  motion_x;
    logic [9:0]                  motion_y;
    logic [9:0]                  init_x;
    logic [9:0]                  init_y;

    // Outputs from the scheduler
    logic [NUM_SLOTS-1:0]        bullet_active;
    logic [NUM_SLOTS*10-1:0]     bullet_x;
    logic [NUM_SLOTS*10-1:0]     bullet_y;
    logic                        fire_accept;
    logic                        fire_reject;
    logic                        cooldown_busy;
    logic [$clog2(NUM_SLOTS+1)-1:0] free_count;

    modport master (
        output frame_tick, keycode, motion_x, motion_y, init_x, init_y,
        input  bullet_active, bullet_x, bullet_y,
        input  fire_accept, fire_reject, cooldown_busy, free_count
    );

    modport slave (
        input  frame_tick, keycode, motion_x, motion_y, init_x, init_y,
        output bullet_active, bullet_x, bullet_y,
        output fire_accept, fire_reject, cooldown_busy, free_count
    );
endinterface

// File: rtl/bullet_scheduler.sv
// Bullet scheduler: launches bullets into the lowest free slot on a fire-key
// press edge, enforces a frame-based cooldown between shots, and advances /
// retires in-flight bullets once per video frame.
module bullet_scheduler #(
    parameter int         NUM_SLOTS       = 4,
    parameter int         COOLDOWN_FRAMES = 15,
    parameter logic [7:0] FIRE_KEY        = 8'h2C,
    parameter int         SCREEN_W        = 640,
    parameter int         SCREEN_H        = 480
) (
    input  logic              Clk,
    input  logic              Reset,     // synchronous, active-low
    bullet_scheduler_if.slave bus
);

    localparam int CNT_W  = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam int FREE_W = $clog2(NUM_SLOTS + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [9:0]       X_MAX    = 10'(SCREEN_W - 1);
    localparam logic [9:0]       Y_MAX    = 10'(SCREEN_H - 1);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_COOLDOWN = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_q;
    logic             fire_accept_q, fire_reject_q;

    // ------------------------------------------------------------------
    // Press detection and launch decision
    // ------------------------------------------------------------------
    logic                 key_hit;
    logic                 press;
    logic                 any_free;
    logic                 accept;
    logic                 reject;
    logic [NUM_SLOTS-1:0] active_w;
    logic [NUM_SLOTS-1:0] load_sel;
    logic                 sel_found;

    assign key_hit  = (bus.keycode == FIRE_KEY);
    assign press    = key_hit && !key_q;
    assign any_free = ~&active_w;
    assign accept   = (state_q == ST_IDLE) && press && any_free;
    assign reject   = (state_q == ST_IDLE) && press && !any_free;

    // Pick the lowest-index slot that was inactive before this edge; a slot
    // retiring on this same edge still reads as active and is not chosen.
    always_comb begin
        load_sel  = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!active_w[i] && !sel_found) begin
                load_sel[i] = 1'b1;
                sel_found   = 1'b1;
            end
        end
    end

    // Cooldown FSM next-state: a shot arms the counter, frame ticks drain it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (bus.frame_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers: FSM, key history and registered status pulses.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            key_q         <= 1'b0;
            fire_accept_q <= 1'b0;
            fire_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_q         <= key_hit;
            fire_accept_q <= accept;
            fire_reject_q <= reject;
        end
    end

    // ------------------------------------------------------------------
    // Bullet slots
    // ------------------------------------------------------------------
    logic [NUM_SLOTS*10-1:0] bullet_x_w;
    logic [NUM_SLOTS*10-1:0] bullet_y_w;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic [9:0] pos_x_q, pos_x_d;
            logic [9:0] pos_y_q, pos_y_d;
            logic [9:0] vel_x_q, vel_x_d;
            logic [9:0] vel_y_q, vel_y_d;
            logic       act_q, act_d;
            logic [9:0] next_x;
            logic [9:0] next_y;
            logic       off_screen;

            // Wraps modulo 1024, so a negative step off the top lands at a
            // large unsigned value and is caught by the same limit compare.
            assign next_x     = pos_x_q + vel_x_q;
            assign next_y     = pos_y_q + vel_y_q;
            assign off_screen = (next_x > X_MAX) || (next_y > Y_MAX);

            // Slot next-state: launch takes precedence (a freshly loaded slot
            // does not move this edge); otherwise an in-flight slot advances
            // or retires on a frame tick. Velocity is only captured at launch.
            always_comb begin
                pos_x_d = pos_x_q;
                pos_y_d = pos_y_q;
                vel_x_d = vel_x_q;
                vel_y_d = vel_y_q;
                act_d   = act_q;
                if (accept && load_sel[gi]) begin
                    pos_x_d = bus.init_x;
                    pos_y_d = bus.init_y;
                    vel_x_d = bus.motion_x;
                    vel_y_d = bus.motion_y;
                    act_d   = 1'b1;
                end else if (bus.frame_tick && act_q) begin
                    if (off_screen) begin
                        act_d = 1'b0;
                    end else begin
                        pos_x_d = next_x;
                        pos_y_d = next_y;
                    end
                end
            end

            // Slot registers.
            always_ff @(posedge Clk) begin
                if (!Reset) begin
                    pos_x_q <= '0;
                    pos_y_q <= '0;
                    vel_x_q <= '0;
                    vel_y_q <= '0;
                    act_q   <= 1'b0;
                end else begin
                    pos_x_q <= pos_x_d;
                    pos_y_q <= pos_y_d;
                    vel_x_q <= vel_x_d;
                    vel_y_q <= vel_y_d;
                    act_q   <= act_d;
                end
            end

            assign active_w[gi]            = act_q;
            assign bullet_x_w[gi*10 +: 10] = pos_x_q;
            assign bullet_y_w[gi*10 +: 10] = pos_y_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [FREE_W-1:0] free_cnt_w;

    // Number of idle slots, counted straight from the active flags.
    always_comb begin
        free_cnt_w = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_cnt_w = free_cnt_w + FREE_W'(!active_w[i]);
        end
    end

    assign bus.bullet_active = active_w;
    assign bus.bullet_x      = bullet_x_w;
    assign bus.bullet_y      = bullet_y_w;
    assign bus.fire_accept   = fire_accept_q;
    assign bus.fire_reject   = fire_reject_q;
    assign bus.cooldown_busy = (state_q == ST_COOLDOWN);
    assign bus.free_count    = free_cnt_w;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: launch, cooldown, slot exhaustion,
// retirement, same-edge launch/move and reset priority.
module tb_bullet_scheduler;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   accepts;

    bullet_scheduler_if #(.NUM_SLOTS(4)) bus ();

    bullet_scheduler dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.keycode    = 8'h00;
        bus.frame_tick = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_shot(input logic [9:0] ix, input logic [9:0] iy,
                            input logic [9:0] mx, input logic [9:0] my);
        bus.init_x   = ix;
        bus.init_y   = iy;
        bus.motion_x = mx;
        bus.motion_y = my;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        accepts        = 0;
        bus.frame_tick = 1'b0;
        bus.keycode    = 8'h00;
        set_shot(10'd0, 10'd0, 10'd0, 10'd0);

        // ---------------- Reset state ----------------
        do_reset();
        chk("rst_active", 40'(bus.bullet_active), 40'd0);
        chk("rst_free",   40'(bus.free_count), 40'd4);
        chk("rst_busy",   40'(bus.cooldown_busy), 40'd0);
        chk("rst_acc",    40'(bus.fire_accept), 40'd0);
        chk("rst_rej",    40'(bus.fire_reject), 40'd0);
        chk("rst_x",      40'(bus.bullet_x), 40'd0);
        chk("rst_y",      40'(bus.bullet_y), 40'd0);

        // ---------------- Single launch and motion ----------------
        set_shot(10'd85, 10'd40, 10'd1, 10'd0);
        bus.keycode = 8'h2C;
        step();
        chk("t1_acc",    40'(bus.fire_accept), 40'd1);
        chk("t1_active", 40'(bus.bullet_active), 40'b0001);
        chk("t1_s0x",    40'(bus.bullet_x[9:0]), 40'd85);
        chk("t1_s0y",    40'(bus.bullet_y[9:0]), 40'd40);
        chk("t1_busy",   40'(bus.cooldown_busy), 40'd1);
        chk("t1_free",   40'(bus.free_count), 40'd3);
        bus.keycode = 8'h00;
        set_shot(10'd7, 10'd7, 10'd9, 10'd9);   // later changes must not affect slot0
        step();
        chk("t1_acc_end", 40'(bus.fire_accept), 40'd0);
        repeat (3) tick();
        chk("t1_s0x_3t", 40'(bus.bullet_x[9:0]), 40'd88);
        chk("t1_s0y_3t", 40'(bus.bullet_y[9:0]), 40'd40);

        // ---------------- Held key fires once ----------------
        do_reset();
        set_shot(10'd100, 10'd50, 10'd0, 10'd0);
        for (int i = 0; i < 100; i++) begin
            bus.keycode    = 8'h2C;
            bus.frame_tick = ((i % 5) == 4);
            step();
            if (bus.fire_accept) accepts++;
        end
        bus.frame_tick = 1'b0;
        chk("t2_accepts", 40'(accepts), 40'd1);
        chk("t2_busy",    40'(bus.cooldown_busy), 40'd0);
        chk("t2_active",  40'(bus.bullet_active), 40'b0001);
        bus.keycode = 8'h00;
        step();
        set_shot(10'd200, 10'd60, 10'd0, 10'd0);
        bus.keycode = 8'h2C;
        step();
        chk("t2_acc",    40'(bus.fire_accept), 40'd1);
        chk("t2_active", 40'(bus.bullet_active), 40'b0011);
        chk("t2_s1x",    40'(bus.bullet_x[19:10]), 40'd200);
        chk("t2_s1y",    40'(bus.bullet_y[19:10]), 40'd60);
        bus.keycode = 8'h00;

        // ---------------- Fill all slots, then reject ----------------
        repeat (14) tick();
        chk("t3_busy_14", 40'(bus.cooldown_busy), 40'd1);
        tick();
        chk("t3_busy_15", 40'(bus.cooldown_busy), 40'd0);
        set_shot(10'd300, 10'd70, 10'd0, 10'd0);
        bus.keycode = 8'h2C;
        step();
        chk("t3_acc2",   40'(bus.fire_accept), 40'd1);
        chk("t3_s2x",    40'(bus.bullet_x[29:20]), 40'd300);
        bus.keycode = 8'h00;
        repeat (15) tick();
        set_shot(10'd400, 10'd80, 10'd0, 10'd0);
        bus.keycode = 8'h2C;
        step();
        chk("t3_acc3",   40'(bus.fire_accept), 40'd1);
        chk("t3_active", 40'(bus.bullet_active), 40'b1111);
        chk("t3_free",   40'(bus.free_count), 40'd0);
        chk("t3_s3y",    40'(bus.bullet_y[39:30]), 40'd80);
        bus.keycode = 8'h00;
        repeat (15) tick();
        set_shot(10'd500, 10'd90, 10'd1, 10'd1);
        bus.keycode = 8'h2C;
        step();
        chk("t3_rej",    40'(bus.fire_reject), 40'd1);
        chk("t3_noacc",  40'(bus.fire_accept), 40'd0);
        chk("t3_busy_r", 40'(bus.cooldown_busy), 40'd0);
        chk("t3_act_r",  40'(bus.bullet_active), 40'b1111);
        chk("t3_x_r",    40'(bus.bullet_x), {10'd400, 10'd300, 10'd200, 10'd100});
        chk("t3_y_r",    40'(bus.bullet_y), {10'd80, 10'd70, 10'd60, 10'd50});
        bus.keycode = 8'h00;
        step();
        chk("t3_rej_end", 40'(bus.fire_reject), 40'd0);

        // ---------------- Retirement at right edge ----------------
        do_reset();
        set_shot(10'd639, 10'd40, 10'd1, 10'd0);
        bus.keycode = 8'h2C;
        step();
        chk("t4_act_on",  40'(bus.bullet_active), 40'b0001);
        bus.keycode = 8'h00;
        tick();
        chk("t4_act_off", 40'(bus.bullet_active), 40'b0000);
        chk("t4_free",    40'(bus.free_count), 40'd4);

        // ---------------- Retirement by wrap off the top ----------------
        do_reset();
        set_shot(10'd10, 10'd0, 10'd0, 10'h3FF);
        bus.keycode = 8'h2C;
        step();
        chk("t4b_act_on",  40'(bus.bullet_active), 40'b0001);
        bus.keycode = 8'h00;
        tick();
        chk("t4b_act_off", 40'(bus.bullet_active), 40'b0000);

        // ---------------- Launch and frame tick on the same edge ----------------
        do_reset();
        set_shot(10'd70, 10'd85, 10'd2, 10'd1);
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
        repeat (15) tick();
        chk("t5_s0x_pre", 40'(bus.bullet_x[9:0]), 40'd100);
        chk("t5_s0y_pre", 40'(bus.bullet_y[9:0]), 40'd100);
        chk("t5_idle",    40'(bus.cooldown_busy), 40'd0);
        set_shot(10'd50, 10'd60, 10'd3, 10'd3);
        bus.keycode    = 8'h2C;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        chk("t5_acc",    40'(bus.fire_accept), 40'd1);
        chk("t5_active", 40'(bus.bullet_active), 40'b0011);
        chk("t5_s0x",    40'(bus.bullet_x[9:0]), 40'd102);
        chk("t5_s0y",    40'(bus.bullet_y[9:0]), 40'd101);
        chk("t5_s1x",    40'(bus.bullet_x[19:10]), 40'd50);
        chk("t5_s1y",    40'(bus.bullet_y[19:10]), 40'd60);
        bus.keycode = 8'h00;
        tick();
        chk("t5_s1x_t",  40'(bus.bullet_x[19:10]), 40'd53);
        chk("t5_s0y_t",  40'(bus.bullet_y[9:0]), 40'd102);

        // ---------------- Reset mid-cooldown with slots in flight ----------------
        chk("t6_busy_pre", 40'(bus.cooldown_busy), 40'd1);
        rst_n          = 1'b0;
        bus.keycode    = 8'h2C;
        bus.frame_tick = 1'b1;
        step();
        chk("t6_active", 40'(bus.bullet_active), 40'd0);
        chk("t6_free",   40'(bus.free_count), 40'd4);
        chk("t6_busy",   40'(bus.cooldown_busy), 40'd0);
        chk("t6_acc",    40'(bus.fire_accept), 40'd0);
        chk("t6_x",      40'(bus.bullet_x), 40'd0);
        rst_n          = 1'b1;
        bus.frame_tick = 1'b0;
        set_shot(10'd5, 10'd6, 10'd0, 10'd0);
        step();
        chk("t6_acc2",   40'(bus.fire_accept), 40'd1);
        chk("t6_act2",   40'(bus.bullet_active), 40'b0001);
        chk("t6_s0x",    40'(bus.bullet_x[9:0]), 40'd5);
        chk("t6_s0y",    40'(bus.bullet_y[9:0]), 40'd6);
        bus.keycode = 8'h00;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
